// File: rtl/proc_pkg.sv
// Shared definitions for the processor front end: instruction width,
// fetch FSM state encoding and the default reset fetch address.
package proc_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of {instruction, address} with a registered head
// output that holds its last value when the queue drains.
module fetch_queue
    import proc_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int FQ_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [INST_W-1:0] i_inst,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic              o_empty,
    output logic              o_full,
    output logic [FQ_LOG2:0]  o_count,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_pc
);

    localparam int               DEPTH   = 1 << FQ_LOG2;
    localparam logic [FQ_LOG2:0] DEPTH_C = (FQ_LOG2 + 1)'(DEPTH);
    localparam logic [FQ_LOG2:0] ONE_C   = (FQ_LOG2 + 1)'(1);

    logic [INST_W-1:0]  r_mem_inst [DEPTH];
    logic [ADDR_W-1:0]  r_mem_pc   [DEPTH];
    logic [FQ_LOG2-1:0] r_wr_ptr;
    logic [FQ_LOG2-1:0] r_rd_ptr;
    logic [FQ_LOG2:0]   r_count;
    logic [INST_W-1:0]  r_head_inst;
    logic [ADDR_W-1:0]  r_head_pc;

    logic               w_empty;
    logic               w_full;
    logic               w_do_push;
    logic               w_do_pop;
    logic [FQ_LOG2-1:0] w_rd_next;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign w_rd_next = r_rd_ptr + FQ_LOG2'(1);

    // NOTE: storage array has no reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem_inst[r_wr_ptr] <= i_inst;
            r_mem_pc[r_wr_ptr]   <= i_pc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_head_inst <= '0;
            r_head_pc   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + FQ_LOG2'(1);
            if (w_do_pop)  r_rd_ptr <= w_rd_next;

            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + ONE_C;
                2'b01:   r_count <= r_count - ONE_C;
                default: r_count <= r_count;
            endcase

            // Head tracks the oldest live entry; a push into an empty or emptying queue bypasses storage.
            if (w_do_pop) begin
                if (r_count > ONE_C) begin
                    r_head_inst <= r_mem_inst[w_rd_next];
                    r_head_pc   <= r_mem_pc[w_rd_next];
                end else if (w_do_push) begin
                    r_head_inst <= i_inst;
                    r_head_pc   <= i_pc;
                end
            end else if (w_empty && w_do_push) begin
                r_head_inst <= i_inst;
                r_head_pc   <= i_pc;
            end
        end
    end

    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_count = r_count;
    assign o_inst  = r_head_inst;
    assign o_pc    = r_head_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch engine: issues one word address at a time to instruction memory,
// queues returned words for decode and discards stale data after redirects.
module instruction_fetch_unit
    import proc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                FQ_LOG2  = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] pc,
    output logic              req,
    input  logic              a_ready,
    input  logic [INST_W-1:0] instruction,
    input  logic              d_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam logic [FQ_LOG2:0] DEPTH_M1 = (FQ_LOG2 + 1)'((1 << FQ_LOG2) - 1);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] r_req_pc;

    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [FQ_LOG2:0]  w_count;
    logic              w_idle_go;
    logic              w_wait_go;

    assign w_accept = (r_state == ST_REQ) && a_ready && !redirect;
    assign w_push   = (r_state == ST_WAIT) && d_ready && !redirect;
    assign w_pop    = !w_empty && inst_ready;

    // A new request is only issued when its response is guaranteed a slot (after this cycle's pop/push).
    assign w_idle_go = !w_full || w_pop;
    assign w_wait_go = w_pop || (w_count < DEPTH_M1);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;

        if (redirect) begin
            w_pc_next = redirect_pc;
            case (r_state)
                ST_REQ:             w_state_next = a_ready ? ST_DRAIN : ST_REQ;
                ST_WAIT, ST_DRAIN:  w_state_next = d_ready ? ST_REQ : ST_DRAIN;
                default:            w_state_next = ST_REQ;
            endcase
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_idle_go) w_state_next = ST_REQ;
                end
                ST_REQ: begin
                    if (a_ready) begin
                        w_pc_next    = r_pc + ADDR_W'(1);
                        w_state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (d_ready) w_state_next = w_wait_go ? ST_REQ : ST_IDLE;
                end
                ST_DRAIN: begin
                    if (d_ready) w_state_next = ST_REQ;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_accept) r_req_pc <= r_pc;
        end
    end

    fetch_queue #(
        .ADDR_W  (ADDR_W),
        .FQ_LOG2 (FQ_LOG2)
    ) u_fetch_queue (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_inst  (instruction),
        .i_pc    (r_req_pc),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count),
        .o_inst  (inst),
        .o_pc    (inst_pc)
    );

    assign pc         = r_pc;
    assign req        = (r_state == ST_REQ);
    assign inst_valid = !w_empty;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a behavioural memory answers
// accepted requests and the expected decode stream is queued as words return.
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        req;
    logic        a_ready;
    logic [31:0] instruction;
    logic        d_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int total = 0;
    int bad   = 0;

    entry_t      sb[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];

    bit          mem_pend;
    bit          mem_stale;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          mem_lat;
    bit          force_d;

    instruction_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .req         (req),
        .a_ready     (a_ready),
        .instruction (instruction),
        .d_ready     (d_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock of stimulus; called at a falling edge with test inputs already set.
    task automatic cycle();
        bit     acc;
        bit     popv;
        bit     ret;
        entry_t e;
        if (force_d) begin
            d_ready = 1'b1; instruction = 32'hDEAD_BEEF;
        end else if (mem_pend && mem_cnt == 0) begin
            d_ready = 1'b1; instruction = word_of(mem_addr);
        end else begin
            d_ready = 1'b0; instruction = 32'h0;
        end
        acc  = (req === 1'b1) && a_ready;
        popv = (inst_valid === 1'b1) && inst_ready;
        ret  = d_ready;

        if (popv && !redirect) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got pc=%h inst=%h, expected no valid data", inst_pc, inst);
            end else begin
                e = sb.pop_front();
                if (inst !== e.inst || inst_pc !== e.pc) begin
                    bad++;
                    $display("FAIL pop_data: got pc=%h inst=%h, expected pc=%h inst=%h", inst_pc, inst, e.pc, e.inst);
                end
                pop_log.push_back(inst_pc);
            end
        end
        if (ret && mem_pend) begin
            if (!mem_stale && !redirect) sb.push_back('{inst: word_of(mem_addr), pc: mem_addr});
            mem_pend = 1'b0;
        end
        if (redirect) begin
            sb.delete();
            if (mem_pend) mem_stale = 1'b1;
        end
        if (acc) begin
            total++;
            if (mem_pend) begin
                bad++;
                $display("FAIL outstanding: got second accept pc=%h, expected at most one in flight", pc);
            end
            acc_log.push_back(pc);
            mem_pend  = 1'b1;
            mem_addr  = pc;
            mem_cnt   = mem_lat - 1;
            mem_stale = redirect;
        end else if (mem_pend && mem_cnt > 0) begin
            mem_cnt--;
        end

        @(posedge clk);
        @(negedge clk);
        total++;
        if (inst_valid !== (sb.size() != 0)) begin
            bad++;
            $display("FAIL inst_valid: got %b, expected %b", inst_valid, sb.size() != 0);
        end
    endtask

    task automatic wait_acc(input int n, input string name);
        int k = 0;
        while (acc_log.size() < n && k < 60) begin cycle(); k++; end
        if (acc_log.size() < n) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d accepts, expected %0d", name, acc_log.size(), n);
        end
    endtask

    task automatic wait_pop(input int n, input string name);
        int k = 0;
        while (pop_log.size() < n && k < 60) begin cycle(); k++; end
        if (pop_log.size() < n) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d pops, expected %0d", name, pop_log.size(), n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        a_ready = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        d_ready = 1'b0; instruction = '0; force_d = 1'b0;
        mem_pend = 1'b0; mem_stale = 1'b0; mem_cnt = 0; mem_lat = 1; mem_addr = '0;
        sb.delete(); acc_log.delete(); pop_log.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total += 5;
        if (pc !== 32'h0)       begin bad++; $display("FAIL reset_pc: got %h, expected 0", pc); end
        if (req !== 1'b0)       begin bad++; $display("FAIL reset_req: got %b, expected 0", req); end
        if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, expected 0", inst_valid); end
        if (inst !== 32'h0)     begin bad++; $display("FAIL reset_inst: got %h, expected 0", inst); end
        if (inst_pc !== 32'h0)  begin bad++; $display("FAIL reset_inst_pc: got %h, expected 0", inst_pc); end
    endtask

    task automatic test_stream();
        do_reset();
        a_ready = 1'b1; inst_ready = 1'b1; mem_lat = 1;
        repeat (20) cycle();
        total += 2;
        if (acc_log.size() < 9) begin bad++; $display("FAIL stream_rate: got %0d accepts, expected >= 9", acc_log.size()); end
        if (pop_log.size() < 8) begin bad++; $display("FAIL stream_pops: got %0d pops, expected >= 8", pop_log.size()); end
        foreach (acc_log[i]) begin
            total++;
            if (acc_log[i] !== 32'(i)) begin bad++; $display("FAIL stream_pc: got %h, expected %h", acc_log[i], 32'(i)); end
        end
        foreach (pop_log[i]) begin
            total++;
            if (pop_log[i] !== 32'(i)) begin bad++; $display("FAIL stream_inst_pc: got %h, expected %h", pop_log[i], 32'(i)); end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        a_ready = 1'b1; inst_ready = 1'b0; mem_lat = 1;
        repeat (20) cycle();
        total += 4;
        if (acc_log.size() != 4) begin bad++; $display("FAIL bp_accepts: got %0d, expected 4", acc_log.size()); end
        if (req !== 1'b0)        begin bad++; $display("FAIL bp_req: got %b, expected 0", req); end
        if (inst_pc !== 32'h0)   begin bad++; $display("FAIL bp_head_pc: got %h, expected 0", inst_pc); end
        if (inst !== word_of(32'h0)) begin bad++; $display("FAIL bp_head_inst: got %h, expected %h", inst, word_of(32'h0)); end
        inst_ready = 1'b1;
        repeat (20) cycle();
        total++;
        if (pop_log.size() < 6) begin bad++; $display("FAIL bp_resume: got %0d pops, expected >= 6", pop_log.size()); end
        foreach (pop_log[i]) begin
            total++;
            if (pop_log[i] !== 32'(i)) begin bad++; $display("FAIL bp_order: got %h, expected %h", pop_log[i], 32'(i)); end
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        a_ready = 1'b1; inst_ready = 1'b1; mem_lat = 3;
        wait_acc(2, "rw_setup");
        redirect = 1'b1; redirect_pc = 32'h40;
        acc_log.delete(); pop_log.delete();
        cycle();
        redirect = 1'b0;
        total++;
        if (req !== 1'b0) begin bad++; $display("FAIL rw_drain_req: got %b, expected 0", req); end
        wait_pop(1, "rw_pop");
        total += 2;
        if (pop_log.size() == 0 || pop_log[0] !== 32'h40) begin
            bad++; $display("FAIL rw_first_pc: got %h, expected 00000040", pop_log.size() ? pop_log[0] : 32'hx);
        end
        if (acc_log.size() == 0 || acc_log[0] !== 32'h40) begin
            bad++; $display("FAIL rw_first_acc: got %h, expected 00000040", acc_log.size() ? acc_log[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_accept();
        int k = 0;
        do_reset();
        a_ready = 1'b1; inst_ready = 1'b1; mem_lat = 1;
        wait_acc(2, "ra_setup");
        while (req !== 1'b1 && k < 10) begin cycle(); k++; end
        redirect = 1'b1; redirect_pc = 32'h80;
        acc_log.delete(); pop_log.delete();
        cycle();
        redirect = 1'b0;
        total++;
        if (req !== 1'b0) begin bad++; $display("FAIL ra_drain_req: got %b, expected 0", req); end
        wait_acc(2, "ra_acc");
        wait_pop(1, "ra_pop");
        total += 2;
        if (acc_log.size() < 2 || acc_log[1] !== 32'h80) begin
            bad++; $display("FAIL ra_next_acc: got %h, expected 00000080", acc_log.size() > 1 ? acc_log[1] : 32'hx);
        end
        if (pop_log.size() == 0 || pop_log[0] !== 32'h80) begin
            bad++; $display("FAIL ra_first_pc: got %h, expected 00000080", pop_log.size() ? pop_log[0] : 32'hx);
        end
    endtask

    task automatic test_reset_mid_wait();
        int k = 0;
        do_reset();
        a_ready = 1'b1; inst_ready = 1'b0; mem_lat = 3;
        while (!(sb.size() == 2 && mem_pend) && k < 60) begin cycle(); k++; end
        total++;
        if (!(sb.size() == 2 && mem_pend)) begin bad++; $display("FAIL rst_setup: got %0d queued, expected 2 plus one in flight", sb.size()); end
        #2 reset = 1'b0;
        #1;
        total += 4;
        if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, expected 0", inst_valid); end
        if (req !== 1'b0)        begin bad++; $display("FAIL rst_req: got %b, expected 0", req); end
        if (pc !== 32'h0)        begin bad++; $display("FAIL rst_pc: got %h, expected 0", pc); end
        if (inst !== 32'h0)      begin bad++; $display("FAIL rst_inst: got %h, expected 0", inst); end
        sb.delete(); mem_pend = 1'b0; mem_stale = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        force_d = 1'b1;
        cycle();
        force_d = 1'b0;
        total++;
        if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_late_data: got valid %b, expected 0", inst_valid); end
        inst_ready = 1'b1; mem_lat = 1;
        acc_log.delete(); pop_log.delete();
        wait_pop(1, "rst_resume");
        total++;
        if (pop_log.size() == 0 || pop_log[0] !== 32'h0) begin
            bad++; $display("FAIL rst_resume_pc: got %h, expected 0", pop_log.size() ? pop_log[0] : 32'hx);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        a_ready = 1'b1; inst_ready = 1'b1; mem_lat = 1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        cycle();
        redirect = 1'b0;
        wait_acc(3, "wrap_acc");
        wait_pop(2, "wrap_pop");
        total += 3;
        if (acc_log.size() < 3 || acc_log[0] !== 32'hFFFF_FFFF || acc_log[1] !== 32'h0 || acc_log[2] !== 32'h1) begin
            bad++;
            $display("FAIL wrap_acc_seq: got %h %h %h, expected ffffffff 00000000 00000001",
                     acc_log.size() > 0 ? acc_log[0] : 32'hx, acc_log.size() > 1 ? acc_log[1] : 32'hx,
                     acc_log.size() > 2 ? acc_log[2] : 32'hx);
        end
        if (pop_log.size() < 1 || pop_log[0] !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL wrap_pop0: got %h, expected ffffffff", pop_log.size() > 0 ? pop_log[0] : 32'hx);
        end
        if (pop_log.size() < 2 || pop_log[1] !== 32'h0) begin
            bad++; $display("FAIL wrap_pop1: got %h, expected 00000000", pop_log.size() > 1 ? pop_log[1] : 32'hx);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_redirect_wait();
        test_redirect_accept();
        test_reset_mid_wait();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
